// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and the
// elaboration-time helpers that turn clock/baud/format parameters into sizes.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } tx_state_e;

  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1, flags the last count (tick) and the
// one before it (pre_tick) so registered outputs can be armed a clock early.
module uart_baud_tick #(
  parameter int BAUD_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick     = (cnt == CNT_LAST);
  assign pre_tick = (cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (data width, parity, stop bits) with a
// valid/ready byte input that supports zero-gap back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50250000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int BAUD_DIV  = calc_baud_div(CLK_HZ, BAUD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_val_i,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 data_rdy_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tx
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_cfg: BAUD_DIV must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  tx_state_e state, state_next;

  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] frame_load;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  rdy_q;
  logic                  done_q;
  logic                  accept;
  logic                  tick;
  logic                  pre_tick;
  logic                  last_bit;
  logic                  parity_bit;

  assign accept     = data_val_i && rdy_q;
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign data_rdy_o = rdy_q;
  assign done_o     = done_q;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (accept),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  assign parity_bit = (PARITY == PAR_ODD) ? ~(^data_in) : (^data_in);

  // The whole frame is latched at accept; stop bits come from the '1 fill.
  always_comb begin
    frame_load                = '1;
    frame_load[0]             = 1'b0;
    frame_load[DATA_BITS:1]   = data_in;
    if (PARITY != PAR_NONE) begin
      frame_load[DATA_BITS+1] = parity_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    busy_o     = 1'b0;
    tx         = 1'b1;
    case (state)
      ST_IDLE: begin
        state_next = accept ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        busy_o     = 1'b1;
        tx         = shift_reg[0];
        state_next = (tick && last_bit && !accept) ? ST_IDLE : ST_SHIFT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Ready and done are armed at pre_tick so both are high on exactly the
  // final clock of the last stop bit, allowing a gapless follow-on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '1;
      bit_cnt   <= '0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
    end else if (accept) begin
      shift_reg <= frame_load;
      bit_cnt   <= '0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (state == ST_SHIFT) begin
      done_q <= pre_tick && last_bit;
      if (pre_tick && last_bit) begin
        rdy_q <= 1'b1;
      end
      if (tick) begin
        shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
        bit_cnt   <= last_bit ? '0 : (bit_cnt + BIT_W'(1));
      end
    end else begin
      shift_reg <= '1;
      bit_cnt   <= '0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
    end
  end

endmodule
